// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types and constants for the two-port SRAM arbiter.
//   - rsp_state_t : response slot states (idle, response in flight, held)
//   - NUM_PORTS   : number of requesters sharing the SRAM
//   - PORT_IFETCH : index of the instruction-fetch port
//   - PORT_LSU    : index of the load/store port
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    typedef enum logic [1:0] {
        RSP_IDLE     = 2'd0,
        RSP_INFLIGHT = 2'd1,
        RSP_HELD     = 2'd2
    } rsp_state_t;

    localparam int unsigned NUM_PORTS   = 2;
    localparam int unsigned PORT_IFETCH = 0;
    localparam int unsigned PORT_LSU    = 1;

endpackage

// File: rtl/sram_arb_rsp_slot.sv
// -----------------------------------------------------------------------------
// sram_arb_rsp_slot
//   Response holding slot for one arbiter port. The SRAM returns read data one
//   cycle after a grant; if the requester does not accept it in that cycle the
//   word is copied into a local hold register, because the other port may use
//   the SRAM in the same cycle and overwrite douta.
//
//   Ports:
//     clka       in   clock
//     resetn     in   asynchronous active-low reset
//     grant      in   this port is granted an SRAM access this cycle
//     sram_douta in   SRAM read data (valid the cycle after a grant)
//     rsp_ready  in   requester consumes the response this cycle
//     rsp_valid  out  response available
//     rsp_rdata  out  response data (live douta or held copy)
//     free       out  slot can take a new access this cycle
// -----------------------------------------------------------------------------
module sram_arb_rsp_slot
    import sram_arb_pkg::*;
#(
    parameter int LEN_DATA = 32
) (
    input  logic                clka,
    input  logic                resetn,
    input  logic                grant,
    input  logic [LEN_DATA-1:0] sram_douta,
    input  logic                rsp_ready,
    output logic                rsp_valid,
    output logic [LEN_DATA-1:0] rsp_rdata,
    output logic                free
);

    rsp_state_t          state;
    logic                use_hold;
    logic [LEN_DATA-1:0] hold;

    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            state     <= RSP_IDLE;
            rsp_valid <= 1'b0;
            use_hold  <= 1'b0;
            hold      <= '0;
        end else begin
            case (state)
                RSP_IDLE: begin
                    if (grant) begin
                        state     <= RSP_INFLIGHT;
                        rsp_valid <= 1'b1;
                        use_hold  <= 1'b0;
                    end
                end
                RSP_INFLIGHT: begin
                    if (rsp_ready) begin
                        // A grant here is a back-to-back access: stay in flight.
                        state     <= grant ? RSP_INFLIGHT : RSP_IDLE;
                        rsp_valid <= grant;
                        use_hold  <= 1'b0;
                    end else begin
                        // douta is only guaranteed this cycle; keep a private copy.
                        hold      <= sram_douta;
                        state     <= RSP_HELD;
                        rsp_valid <= 1'b1;
                        use_hold  <= 1'b1;
                    end
                end
                RSP_HELD: begin
                    if (rsp_ready) begin
                        state     <= grant ? RSP_INFLIGHT : RSP_IDLE;
                        rsp_valid <= grant;
                        use_hold  <= 1'b0;
                    end
                end
                default: begin
                    state     <= RSP_IDLE;
                    rsp_valid <= 1'b0;
                    use_hold  <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_rdata = use_hold ? hold : sram_douta;
    assign free      = !rsp_valid || rsp_ready;

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Shares one single-port read-first synchronous SRAM (1-cycle latency, byte
//   write enables, ena-gated output register) between an instruction-fetch
//   port (m0) and a load/store port (m1). Round-robin grant, one access per
//   cycle, per-port response holding so backpressure on one port never blocks
//   or corrupts the other.
//
//   Ports:
//     clka, resetn                      clock, asynchronous active-low reset
//     mX_req_valid/ready                request handshake (ready = granted)
//     mX_req_addr/wdata/wstrb           byte address, write data, byte strobes
//                                       (all-zero strobes = read)
//     mX_rsp_valid/ready, mX_rsp_rdata  response handshake and data (old
//                                       contents for writes)
//     sram_addra/dina/ena/wea           SRAM command, combinational from grant
//     sram_douta                        SRAM read data
// -----------------------------------------------------------------------------
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int LEN_ADDR = 32,
    parameter int LEN_DATA = 32
) (
    input  logic                  clka,
    input  logic                  resetn,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic [LEN_ADDR-1:0]   m0_req_addr,
    input  logic [LEN_DATA-1:0]   m0_req_wdata,
    input  logic [LEN_DATA/8-1:0] m0_req_wstrb,
    output logic                  m0_rsp_valid,
    input  logic                  m0_rsp_ready,
    output logic [LEN_DATA-1:0]   m0_rsp_rdata,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic [LEN_ADDR-1:0]   m1_req_addr,
    input  logic [LEN_DATA-1:0]   m1_req_wdata,
    input  logic [LEN_DATA/8-1:0] m1_req_wstrb,
    output logic                  m1_rsp_valid,
    input  logic                  m1_rsp_ready,
    output logic [LEN_DATA-1:0]   m1_rsp_rdata,

    output logic [LEN_ADDR-1:0]   sram_addra,
    output logic [LEN_DATA-1:0]   sram_dina,
    output logic                  sram_ena,
    output logic [LEN_DATA/8-1:0] sram_wea,
    input  logic [LEN_DATA-1:0]   sram_douta
);

    logic [NUM_PORTS-1:0] free;
    logic [NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0] grant;

    // Index of the last granted port; 1 after reset so port 0 wins the first tie.
    logic rr_last;

    // A port may only issue when its response slot can drain this cycle.
    assign elig[PORT_IFETCH] = m0_req_valid && free[PORT_IFETCH];
    assign elig[PORT_LSU]    = m1_req_valid && free[PORT_LSU];

    always_comb begin
        grant = '0;
        if (elig[PORT_IFETCH] && elig[PORT_LSU]) begin
            if (rr_last) grant[PORT_IFETCH] = 1'b1;
            else         grant[PORT_LSU]    = 1'b1;
        end else begin
            grant = elig;
        end
    end

    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            rr_last <= 1'b1;
        end else if (|grant) begin
            rr_last <= grant[PORT_LSU];
        end
    end

    assign m0_req_ready = grant[PORT_IFETCH];
    assign m1_req_ready = grant[PORT_LSU];

    // SRAM command mux; nothing reaches the SRAM from an ungranted port.
    always_comb begin
        sram_ena   = 1'b0;
        sram_addra = '0;
        sram_dina  = '0;
        sram_wea   = '0;
        if (grant[PORT_IFETCH]) begin
            sram_ena   = 1'b1;
            sram_addra = m0_req_addr;
            sram_dina  = m0_req_wdata;
            sram_wea   = m0_req_wstrb;
        end else if (grant[PORT_LSU]) begin
            sram_ena   = 1'b1;
            sram_addra = m1_req_addr;
            sram_dina  = m1_req_wdata;
            sram_wea   = m1_req_wstrb;
        end
    end

    sram_arb_rsp_slot #(
        .LEN_DATA (LEN_DATA)
    ) u_slot_ifetch (
        .clka       (clka),
        .resetn     (resetn),
        .grant      (grant[PORT_IFETCH]),
        .sram_douta (sram_douta),
        .rsp_ready  (m0_rsp_ready),
        .rsp_valid  (m0_rsp_valid),
        .rsp_rdata  (m0_rsp_rdata),
        .free       (free[PORT_IFETCH])
    );

    sram_arb_rsp_slot #(
        .LEN_DATA (LEN_DATA)
    ) u_slot_lsu (
        .clka       (clka),
        .resetn     (resetn),
        .grant      (grant[PORT_LSU]),
        .sram_douta (sram_douta),
        .rsp_ready  (m1_rsp_ready),
        .rsp_valid  (m1_rsp_valid),
        .rsp_rdata  (m1_rsp_rdata),
        .free       (free[PORT_LSU])
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//   Directed bench for sram_arbiter with a behavioural read-first SRAM.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    logic        clka;
    logic        resetn;

    logic        m0_req_valid;
    logic        m0_req_ready;
    logic [31:0] m0_req_addr;
    logic [31:0] m0_req_wdata;
    logic [3:0]  m0_req_wstrb;
    logic        m0_rsp_valid;
    logic        m0_rsp_ready;
    logic [31:0] m0_rsp_rdata;

    logic        m1_req_valid;
    logic        m1_req_ready;
    logic [31:0] m1_req_addr;
    logic [31:0] m1_req_wdata;
    logic [3:0]  m1_req_wstrb;
    logic        m1_rsp_valid;
    logic        m1_rsp_ready;
    logic [31:0] m1_rsp_rdata;

    logic [31:0] sram_addra;
    logic [31:0] sram_dina;
    logic        sram_ena;
    logic [3:0]  sram_wea;
    logic [31:0] sram_douta;

    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    sram_arbiter #(
        .LEN_ADDR (32),
        .LEN_DATA (32)
    ) dut (
        .clka         (clka),
        .resetn       (resetn),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_req_addr  (m0_req_addr),
        .m0_req_wdata (m0_req_wdata),
        .m0_req_wstrb (m0_req_wstrb),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_ready (m0_rsp_ready),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_req_addr  (m1_req_addr),
        .m1_req_wdata (m1_req_wdata),
        .m1_req_wstrb (m1_req_wstrb),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_ready (m1_rsp_ready),
        .m1_rsp_rdata (m1_rsp_rdata),
        .sram_addra   (sram_addra),
        .sram_dina    (sram_dina),
        .sram_ena     (sram_ena),
        .sram_wea     (sram_wea),
        .sram_douta   (sram_douta)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Read-first SRAM: douta gets the pre-write word, output register gated by ena.
    always @(posedge clka) begin
        if (sram_ena) begin
            sram_douta <= mem[sram_addra[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (sram_wea[b]) mem[sram_addra[9:2]][b*8 +: 8] <= sram_dina[b*8 +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic idle_reqs();
        m0_req_valid = 1'b0;
        m0_req_addr  = '0;
        m0_req_wdata = '0;
        m0_req_wstrb = '0;
        m1_req_valid = 1'b0;
        m1_req_addr  = '0;
        m1_req_wdata = '0;
        m1_req_wstrb = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[4]  = 32'hDEADBEEF;   // 0x10
        mem[8]  = 32'h11223344;   // 0x20
        mem[12] = 32'hCAFEF00D;   // 0x30
        mem[16] = 32'h55AA55AA;   // 0x40
        mem[20] = 32'h01010101;   // 0x50
        mem[21] = 32'h02020202;   // 0x54
        mem[22] = 32'h03030303;   // 0x58

        idle_reqs();
        m0_rsp_ready = 1'b1;
        m1_rsp_ready = 1'b1;
        resetn       = 1'b0;
        repeat (2) @(posedge clka);
        #1;

        // reset state
        @(negedge clka);
        check("rst_m0_rsp_valid", 64'(m0_rsp_valid), 64'd0);
        check("rst_m1_rsp_valid", 64'(m1_rsp_valid), 64'd0);
        check("rst_sram_ena", 64'(sram_ena), 64'd0);
        check("rst_sram_wea", 64'(sram_wea), 64'd0);
        tick();
        resetn = 1'b1;
        tick();

        // both ports read every cycle: grants alternate starting with port 0
        m0_req_valid = 1'b1; m0_req_addr = 32'h10;
        m1_req_valid = 1'b1; m1_req_addr = 32'h40;
        @(negedge clka);
        check("alt0_g0", 64'(m0_req_ready), 64'd1);
        check("alt0_g1", 64'(m1_req_ready), 64'd0);
        tick();
        @(negedge clka);
        check("alt1_g0", 64'(m0_req_ready), 64'd0);
        check("alt1_g1", 64'(m1_req_ready), 64'd1);
        check("alt1_m0_valid", 64'(m0_rsp_valid), 64'd1);
        check("alt1_m0_rdata", 64'(m0_rsp_rdata), 64'hDEADBEEF);
        check("alt1_m1_valid", 64'(m1_rsp_valid), 64'd0);
        tick();
        @(negedge clka);
        check("alt2_g0", 64'(m0_req_ready), 64'd1);
        check("alt2_m1_valid", 64'(m1_rsp_valid), 64'd1);
        check("alt2_m1_rdata", 64'(m1_rsp_rdata), 64'h55AA55AA);
        check("alt2_m0_valid", 64'(m0_rsp_valid), 64'd0);
        tick();
        @(negedge clka);
        check("alt3_g1", 64'(m1_req_ready), 64'd1);
        check("alt3_m0_rdata", 64'(m0_rsp_rdata), 64'hDEADBEEF);
        tick();
        idle_reqs();
        @(negedge clka);
        check("alt4_m1_rdata", 64'(m1_rsp_rdata), 64'h55AA55AA);
        check("alt4_ena", 64'(sram_ena), 64'd0);
        tick();
        @(negedge clka);
        check("alt5_m0_valid", 64'(m0_rsp_valid), 64'd0);
        check("alt5_m1_valid", 64'(m1_rsp_valid), 64'd0);
        tick();

        // single port 0 read of 0x10
        m0_req_valid = 1'b1; m0_req_addr = 32'h10;
        @(negedge clka);
        check("rd_g0", 64'(m0_req_ready), 64'd1);
        check("rd_ena", 64'(sram_ena), 64'd1);
        check("rd_addr", 64'(sram_addra), 64'h10);
        check("rd_wea", 64'(sram_wea), 64'd0);
        check("rd_valid_T", 64'(m0_rsp_valid), 64'd0);
        tick();
        idle_reqs();
        @(negedge clka);
        check("rd_valid_T1", 64'(m0_rsp_valid), 64'd1);
        check("rd_rdata", 64'(m0_rsp_rdata), 64'hDEADBEEF);
        check("rd_ena_T1", 64'(sram_ena), 64'd0);
        tick();

        // port 1 partial write then read-back
        m1_req_valid = 1'b1; m1_req_addr = 32'h20;
        m1_req_wdata = 32'h0000AB00; m1_req_wstrb = 4'b0010;
        @(negedge clka);
        check("wr_g1", 64'(m1_req_ready), 64'd1);
        check("wr_wea", 64'(sram_wea), 64'h2);
        check("wr_dina", 64'(sram_dina), 64'h0000AB00);
        tick();
        m1_req_wdata = '0; m1_req_wstrb = '0;
        @(negedge clka);
        check("wr_rsp_valid", 64'(m1_rsp_valid), 64'd1);
        check("wr_rsp_old", 64'(m1_rsp_rdata), 64'h11223344);
        check("wr_rb_g1", 64'(m1_req_ready), 64'd1);
        tick();
        idle_reqs();
        @(negedge clka);
        check("wr_rb_rdata", 64'(m1_rsp_rdata), 64'h1122AB44);
        tick();

        // port 0 stalls its response while port 1 streams reads
        m0_req_valid = 1'b1; m0_req_addr = 32'h30; m0_rsp_ready = 1'b0;
        m1_req_valid = 1'b1; m1_req_addr = 32'h40;
        @(negedge clka);
        check("bp0_g0", 64'(m0_req_ready), 64'd1);
        check("bp0_g1", 64'(m1_req_ready), 64'd0);
        tick();
        m0_req_addr = 32'h10;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clka);
            check($sformatf("bp%0d_m0_valid", c), 64'(m0_rsp_valid), 64'd1);
            check($sformatf("bp%0d_m0_rdata", c), 64'(m0_rsp_rdata), 64'hCAFEF00D);
            check($sformatf("bp%0d_g0", c), 64'(m0_req_ready), 64'd0);
            check($sformatf("bp%0d_g1", c), 64'(m1_req_ready), 64'd1);
            if (c > 1) check($sformatf("bp%0d_m1_rdata", c), 64'(m1_rsp_rdata), 64'h55AA55AA);
            tick();
        end
        m0_rsp_ready = 1'b1;
        @(negedge clka);
        check("bp4_m0_rdata", 64'(m0_rsp_rdata), 64'hCAFEF00D);
        check("bp4_g0", 64'(m0_req_ready), 64'd1);
        check("bp4_m1_valid", 64'(m1_rsp_valid), 64'd1);
        tick();
        idle_reqs();
        @(negedge clka);
        check("bp5_m0_rdata", 64'(m0_rsp_rdata), 64'hDEADBEEF);
        check("bp5_m1_valid", 64'(m1_rsp_valid), 64'd0);
        tick();

        // back-to-back port 0 reads, no bubbles
        m0_req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            m0_req_addr = 32'h50 + 32'(4 * c);
            if (c == 3) m0_req_valid = 1'b0;
            @(negedge clka);
            if (c < 3) check($sformatf("b2b%0d_g0", c), 64'(m0_req_ready), 64'd1);
            if (c > 0) begin
                check($sformatf("b2b%0d_valid", c), 64'(m0_rsp_valid), 64'd1);
                check($sformatf("b2b%0d_rdata", c), 64'(m0_rsp_rdata), 64'(32'h01010101 * c));
            end
            tick();
        end
        idle_reqs();

        // reset while port 1 HELD and port 0 INFLIGHT
        m1_req_valid = 1'b1; m1_req_addr = 32'h60;
        m1_req_wdata = 32'h77777777; m1_req_wstrb = 4'hF; m1_rsp_ready = 1'b0;
        @(negedge clka);
        check("rr_wr_g1", 64'(m1_req_ready), 64'd1);
        tick();
        idle_reqs();
        m0_req_valid = 1'b1; m0_req_addr = 32'h10;
        @(negedge clka);
        check("rr_rd_g0", 64'(m0_req_ready), 64'd1);
        tick();
        idle_reqs();
        @(negedge clka);
        check("rr_pre_m0_valid", 64'(m0_rsp_valid), 64'd1);
        check("rr_pre_m0_rdata", 64'(m0_rsp_rdata), 64'hDEADBEEF);
        check("rr_pre_m1_valid", 64'(m1_rsp_valid), 64'd1);
        check("rr_pre_m1_rdata", 64'(m1_rsp_rdata), 64'h0);
        #1;
        resetn = 1'b0;
        #1;
        check("rr_m0_valid_drop", 64'(m0_rsp_valid), 64'd0);
        check("rr_m1_valid_drop", 64'(m1_rsp_valid), 64'd0);
        tick();
        resetn = 1'b1;
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        m0_req_valid = 1'b1; m0_req_addr = 32'h60;
        m1_req_valid = 1'b1; m1_req_addr = 32'h10;
        @(negedge clka);
        check("rr_post_g0", 64'(m0_req_ready), 64'd1);
        check("rr_post_g1", 64'(m1_req_ready), 64'd0);
        tick();
        m0_req_valid = 1'b0;
        @(negedge clka);
        check("rr_post_wr_readback", 64'(m0_rsp_rdata), 64'h77777777);
        check("rr_post_g1b", 64'(m1_req_ready), 64'd1);
        tick();
        idle_reqs();
        @(negedge clka);
        check("rr_post_m1_rdata", 64'(m1_rsp_rdata), 64'hDEADBEEF);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port, read-first synchronous SRAM (1-cycle read latency, byte write enables, `ena`-gated output register) between two requesters.
- Port 0 is instruction fetch; port 1 is load/store.
- Each port has a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one SRAM access per cycle; per-port response holding so that backpressure on one port never corrupts or blocks the other.

Parameters:
- LEN_ADDR, 32, byte-address width (passed straight through to the SRAM).
- LEN_DATA, 32, data width; must be a multiple of 8.

Ports:
- clka  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- m0_req_valid  in  1  port 0 request valid.
- m0_req_ready  out  1  port 0 request accepted (granted) this cycle.
- m0_req_addr  in  LEN_ADDR  port 0 byte address.
- m0_req_wdata  in  LEN_DATA  port 0 write data.
- m0_req_wstrb  in  LEN_DATA/8  port 0 byte strobes; all-zero means read.
- m0_rsp_valid  out  1  port 0 response valid.
- m0_rsp_ready  in  1  port 0 response consumed.
- m0_rsp_rdata  out  LEN_DATA  port 0 read data (old contents for writes).
- m1_*  same set as m0_*  port 1.
- sram_addra  out  LEN_ADDR  to SRAM addra.
- sram_dina  out  LEN_DATA  to SRAM dina.
- sram_ena  out  1  to SRAM ena.
- sram_wea  out  LEN_DATA/8  to SRAM wea.
- sram_douta  in  LEN_DATA  from SRAM douta.

Behaviour:
- Reset (async assert, sync deassert by the consumer):
  - rsp_valid = 0 on both ports; all response slots IDLE; hold registers cleared to 0.
  - rr_last = 1, so port 0 wins the first tie.
  - SRAM outputs are combinational from grant. With no request, sram_ena = 0 and sram_wea = 0.
- Eligibility: port p is eligible in cycle T iff req_valid_p && (!rsp_valid_p || rsp_ready_p).
- Grant:
  - One eligible port: that port is granted.
  - Both eligible: the port != rr_last is granted.
  - rr_last updates to the granted port at the clock edge; it is unchanged when nothing is granted.
- req_ready_p = grant_p (combinational; may depend on req_valid and rsp_ready).
- On grant in T:
  - sram_ena = 1, sram_addra = req_addr, sram_dina = req_wdata, sram_wea = req_wstrb.
  - The ungranted port sees no SRAM effect.
- Response slot FSM per port, states IDLE, INFLIGHT, HELD:
  - IDLE -> INFLIGHT when the port is granted.
  - INFLIGHT: rsp_valid = 1, rsp_rdata = sram_douta (the douta of the T+1 cycle).
    - If rsp_ready: -> INFLIGHT if re-granted this cycle, else -> IDLE.
    - If !rsp_ready: capture sram_douta into hold_p, -> HELD.
  - HELD: rsp_valid = 1, rsp_rdata = hold_p.
    - If rsp_ready: -> INFLIGHT if re-granted, else IDLE.
    - Else stay in HELD. No grant is possible in HELD without rsp_ready (eligibility rule).
- Latency and throughput:
  - Response appears the cycle after grant (1-cycle latency).
  - Sustained 1 access/cycle total with both ports always ready; alternating grants when both request.
- Writes:
  - Always produce a response.
  - Read-first: rdata is the pre-write word.
  - Write data is committed at the grant edge regardless of later response backpressure.
- Hold capture is mandatory: the other port may access the SRAM in T+1 and change douta.
- rsp_valid stays high and rsp_rdata stable until accepted (AXI-style rules). Requesters must hold req_* stable while req_valid && !req_ready.
- Reset mid-operation:
  - In-flight and held responses are discarded.
  - A write granted before reset assertion is committed; a write not yet at an edge is not.

Decomposition:
- Package sram_arb_pkg:
  - typedef enum rsp_state_t {RSP_IDLE, RSP_INFLIGHT, RSP_HELD}.
  - localparam NUM_PORTS = 2.
  - Port index constants PORT_IFETCH = 0, PORT_LSU = 1.
- Sub-module sram_arb_rsp_slot:
  - One response FSM plus hold register.
  - Inputs: grant, sram_douta, rsp_ready. Outputs: rsp_valid, rsp_rdata, free (= !rsp_valid || rsp_ready).
  - Instantiated twice.
- Top contains the round-robin arbiter and SRAM muxing.

Test Plan:
- Port 0 read addr 0x10 (word 4 preloaded 0xDEADBEEF), rsp_ready = 1 -> grant in T; m0_rsp_valid in T+1 with 0xDEADBEEF; sram_ena high only in T.
- Both ports read every cycle, both always ready -> grants alternate 0,1,0,1 starting with port 0; each port gets one response per two cycles with correct data.
- Port 1 write addr 0x20, wstrb 4'b0010, wdata 0x0000AB00 over 0x11223344 -> rsp rdata 0x11223344; subsequent read returns 0x1122AB44.
- Port 0 holds rsp_ready = 0 for 3 cycles after a read of 0xCAFEF00D while port 1 reads 0x55AA55AA every cycle:
  - m0_rsp_rdata stays 0xCAFEF00D throughout.
  - Port 0 gets no further grants until it accepts.
  - Port 1 gets full-rate grants.
- Back-to-back port 0 reads with rsp_ready = 1 while port 1 idle -> one grant per cycle, responses pipelined, no bubbles.
- Assert resetn low while port 1 is in HELD and port 0 is in INFLIGHT:
  - Both rsp_valid drop immediately.
  - After release, the first tie is granted to port 0.
  - The earlier committed write is readable.
